// File: rtl/b_resp_tracker_if.sv
// rtl/b_resp_tracker_if.sv - handshake and status bundle for the write-response tracker
//
// Purpose: groups the write-issue, AXI B channel, hazard and status signals.
// Ports (as seen from the tracker, modport slave):
//   in : wr_issue, wr_issue_addr[31:0], wr_issue_id[1:0]  completed AW+W write
//   in : bid[3:0], bresp[1:0], bvalid                     AXI B channel
//   out: bready                                           AXI B channel ready
//   out: wr_data_ok, wr_data_ok_id[1:0]                   completion pulse to requester
//   in : rd_check_addr[31:0]; out: rd_hazard              read-after-write check
//   out: wr_full, wr_err, outstanding[PTR_W:0]            status
// modport master is the driving side (issue stage, interconnect, read path).
interface b_resp_tracker_if #(
  parameter int PTR_W = 2
);
  logic             wr_issue;
  logic [31:0]      wr_issue_addr;
  logic [1:0]       wr_issue_id;
  logic             wr_full;
  logic [3:0]       bid;
  logic [1:0]       bresp;
  logic             bvalid;
  logic             bready;
  logic             wr_data_ok;
  logic [1:0]       wr_data_ok_id;
  logic [31:0]      rd_check_addr;
  logic             rd_hazard;
  logic             wr_err;
  logic [PTR_W:0]   outstanding;

  modport slave (
    input  wr_issue, wr_issue_addr, wr_issue_id,
    input  bid, bresp, bvalid,
    input  rd_check_addr,
    output wr_full, bready, wr_data_ok, wr_data_ok_id,
    output rd_hazard, wr_err, outstanding
  );

  modport master (
    output wr_issue, wr_issue_addr, wr_issue_id,
    output bid, bresp, bvalid,
    output rd_check_addr,
    input  wr_full, bready, wr_data_ok, wr_data_ok_id,
    input  rd_hazard, wr_err, outstanding
  );
endinterface

// File: rtl/b_resp_tracker.sv
// rtl/b_resp_tracker.sv - in-order AXI write-response tracker with RAW hazard check
//
// Purpose: records each write that completed AW and W, accepts its B response
// in order, pulses wr_data_ok one cycle after the B handshake, and reports
// read-after-write hazards, full status and sticky error status.
// Ports:
//   clk     : clock
//   resetn  : synchronous active-low reset
//   bus     : b_resp_tracker_if.slave (issue, B channel, hazard, status)
module b_resp_tracker #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic               clk,
  input  logic               resetn,
  b_resp_tracker_if.slave    bus
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PENDING,
    ST_FULL
  } state_t;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_nxt;
  state_t           state;

  logic [DEPTH-1:0] ent_valid;
  logic [29:0]      ent_addr [DEPTH];
  logic [1:0]       ent_id   [DEPTH];

  logic             push;
  logic             pop;
  logic             data_ok_q;
  logic [1:0]       data_ok_id_q;
  logic             err_q;
  logic             hazard;
  logic             unused_bits;

  // The occupancy count is the state register; the state is a decode of it.
  always_comb begin
    state     = ST_PENDING;
    pop       = 1'b0;
    push      = 1'b0;
    count_nxt = count;
    if (count == '0) begin
      state = ST_EMPTY;
    end else if (count == FULL_CNT) begin
      state = ST_FULL;
    end
    pop = bus.bvalid && (state != ST_EMPTY);
    // A pop in FULL frees the slot the same-cycle push lands in.
    push = bus.wr_issue && ((state != ST_FULL) || pop);
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      ent_valid    <= '0;
      data_ok_q    <= 1'b0;
      data_ok_id_q <= 2'b00;
      err_q        <= 1'b0;
    end else begin
      count     <= count_nxt;
      data_ok_q <= pop;
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
        data_ok_id_q    <= ent_id[head];
        if (bus.bresp[1]) begin
          err_q <= 1'b1;
        end
      end
      // Placed after the pop clear so a full-state push/pop on the same slot stays valid.
      if (push) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + 1'b1;
      end
    end
  end

  // Payload needs no reset; it is qualified by ent_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= bus.wr_issue_addr[31:2];
      ent_id[tail]   <= bus.wr_issue_id;
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i] == bus.rd_check_addr[31:2])) begin
        hazard = 1'b1;
      end
    end
  end

  // All responses carry the same AXI id and return in order, so bid is not needed.
  assign unused_bits = ^{bus.bid, bus.bresp[0], bus.wr_issue_addr[1:0], bus.rd_check_addr[1:0]};

  assign bus.bready        = (state != ST_EMPTY);
  assign bus.wr_full       = (state == ST_FULL);
  assign bus.outstanding   = count;
  assign bus.wr_data_ok    = data_ok_q;
  assign bus.wr_data_ok_id = data_ok_id_q;
  assign bus.wr_err        = err_q;
  assign bus.rd_hazard     = hazard;

endmodule

// File: doc/b_resp_tracker.md
Name: b_resp_tracker

Overview:
Write-response stage sitting directly downstream of the AXI AW/W issue stage in the AXI bridge. It records every write that completed both the AW and W handshakes, drives the AXI B channel, and returns a one-cycle write data_ok to the originating requester. It also exposes read-after-write hazard and full status. The read path uses these to hold reads that target a word still in flight. The AW/W stage uses them for back-pressure.

Parameters:
DEPTH, 4, maximum number of outstanding writes; power of two, 2..16
PTR_W, 2, log2(DEPTH); pointer width

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
wr_issue  input  1  pulse: a write finished both AW and W handshakes this cycle
wr_issue_addr  input  32  byte address of that write
wr_issue_id  input  2  requester id of that write (2'b01 or 2'b10)
wr_full  output  1  tracker holds DEPTH entries; AW/W stage must not accept a new write
bid  input  4  AXI write response id (always 4'b1 in this bridge; not used for routing)
bresp  input  2  AXI write response code
bvalid  input  1  AXI write response valid
bready  output  1  AXI write response ready
wr_data_ok  output  1  one-cycle pulse: oldest outstanding write has completed
wr_data_ok_id  output  2  requester id of the completed write; valid while wr_data_ok=1
rd_check_addr  input  32  address of a read the read path wants to issue
rd_hazard  output  1  rd_check_addr word matches a pending write
wr_err  output  1  sticky: a B response with bresp[1]=1 (SLVERR/DECERR) was received
outstanding  output  PTR_W+1  current entry count

Behaviour:
- Reset is synchronous with resetn=0. At reset:
  - head, tail and count = 0; all entry valid bits = 0.
  - Outputs: bready=0, wr_data_ok=0, wr_data_ok_id=0, wr_err=0, wr_full=0, rd_hazard=0, outstanding=0.
  - Reset mid-operation discards all entries. A B beat pending on the bus is dropped, because bready=0 during reset.
- Storage is a circular FIFO of DEPTH entries {valid, addr[31:2], id[1:0]}.
  - tail advances on push; head advances on pop; both wrap modulo DEPTH.
- States, derived from count:
  - EMPTY (count=0).
  - PENDING (0<count<DEPTH).
  - FULL (count=DEPTH).
- Push:
  - Occurs on wr_issue=1 and count<DEPTH.
  - Writes addr[31:2] and id at tail and sets its valid bit.
  - wr_issue while FULL is an upstream protocol violation. The entry is dropped and count is unchanged.
- bready = (count!=0), registered-state driven. It does not depend combinationally on bvalid.
- Pop:
  - Occurs on bvalid && bready.
  - Clears valid at head and advances head.
  - Next cycle: wr_data_ok=1 and wr_data_ok_id = id of the popped entry. Latency is exactly 1 cycle from the B handshake.
  - Back-to-back B handshakes give consecutive wr_data_ok pulses.
- Simultaneous push and pop in the same cycle:
  - count is unchanged; both pointers advance.
  - Legal in PENDING and FULL. In FULL, the pop frees the slot the push uses in the same cycle.
- Push into EMPTY with bvalid=1 in the same cycle: no pop that cycle (bready=0). The pop occurs at the earliest on the next cycle.
- wr_full = (count==DEPTH) from registered count. A pop in FULL clears wr_full on the next cycle.
- outstanding = count, registered.
- rd_hazard is combinational: OR over valid entries of (entry.addr[31:2] == rd_check_addr[31:2]).
  - Word granularity only; size and strb are ignored.
  - The same-cycle wr_issue_addr is not included; the AW/W stage covers its own in-flight write.
- wr_err:
  - Set on a pop with bresp[1]=1 and held until reset.
  - An OKAY/EXOKAY response leaves it unchanged.
  - The write is still reported via wr_data_ok.
- bid is ignored. All writes carry AXI id 1, so responses return in order.

Test Plan:
- Single write: wr_issue, addr=0x1C00_0010, id=01; bvalid one cycle later with bresp=00 -> bready=1 from the cycle after push; wr_data_ok=1 with id=01 exactly 1 cycle after the handshake; outstanding returns to 0.
- Fill/drain: 4 pushes (ids 01,10,01,10), bvalid held 0 -> wr_full=1, outstanding=4. Then bvalid=1 for 4 cycles -> 4 consecutive wr_data_ok pulses, ids in order 01,10,01,10; wr_full=0 the cycle after the first pop.
- Simultaneous push/pop at count=2 and again at count=4 -> count stays 2 then 4; completion order preserved; no entry lost.
- Hazard: pending write at 0x0000_1004.
  - rd_check_addr=0x0000_1006 -> rd_hazard=1.
  - rd_check_addr=0x0000_1008 -> rd_hazard=0.
  - After that write's pop, 0x0000_1006 -> rd_hazard=0.
- Error response: pop with bresp=2'b10 -> wr_err=1 next cycle and still wr_data_ok=1; a later bresp=00 leaves wr_err=1.
- Reset mid-operation: 3 entries outstanding, resetn=0 for 1 cycle -> outstanding=0, bready=0, wr_hazard/wr_err/wr_data_ok=0; bvalid during reset produces no wr_data_ok.
